// File: rtl/rbm_host_driver.sv
// Host-side feeder for the RBM inference engine: packs a pixel stream, runs the engine,
// then scans the score snapshot for the signed argmax and hands out a class label.
module rbm_host_driver #(
    parameter int unsigned bitlength        = 12,
    parameter int unsigned input_dim        = 784,
    parameter int unsigned output_dim       = 10,
    parameter int unsigned cnt_width        = 10,
    parameter int unsigned label_width      = 4,
    parameter int unsigned eng_reset_cycles = 2,
    parameter int unsigned timeout_cycles   = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [bitlength-1:0]            pix_data,
    input  logic                            pix_last,
    output logic                            eng_reset,
    output logic                            eng_data_valid,
    output logic [input_dim*bitlength-1:0]  eng_input,
    input  logic [output_dim*bitlength-1:0] eng_output,
    input  logic                            eng_finish,
    output logic                            label_valid,
    input  logic                            label_ready,
    output logic [label_width-1:0]          label,
    output logic [bitlength-1:0]            label_score,
    output logic                            err_len,
    output logic                            err_timeout
);

    localparam logic [2:0] ENG_RST = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] SCAN    = 3'd3;
    localparam logic [2:0] OUT     = 3'd4;

    localparam int unsigned rst_width = $clog2(eng_reset_cycles + 1);

    localparam logic [rst_width-1:0]   rst_last     = rst_width'(eng_reset_cycles - 1);
    localparam logic [cnt_width-1:0]   pix_last_idx = cnt_width'(input_dim - 1);
    localparam logic [label_width-1:0] cls_last_idx = label_width'(output_dim - 1);
    localparam logic [31:0]            run_last     = 32'(timeout_cycles - 1);

    logic [2:0]                      state_q;
    logic [rst_width-1:0]            rst_cnt_q;
    logic [cnt_width-1:0]            cnt_q;
    logic [31:0]                     run_cnt_q;
    logic [input_dim*bitlength-1:0]  eng_input_q;
    logic [output_dim*bitlength-1:0] snap_q;
    logic [label_width-1:0]          idx_q;
    logic [label_width-1:0]          best_idx_q;
    logic [bitlength-1:0]            best_q;
    logic [label_width-1:0]          label_q;
    logic [bitlength-1:0]            label_score_q;
    logic                            err_len_q;
    logic                            err_timeout_q;

    logic                            cnt_at_last;
    logic [bitlength-1:0]            scan_score;
    logic                            scan_gt;
    logic [bitlength-1:0]            best_d;
    logic [label_width-1:0]          best_idx_d;

    assign cnt_at_last = (cnt_q == pix_last_idx);

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        scan_score = snap_q[int'(idx_q)*bitlength +: bitlength];
        scan_gt    = $signed(scan_score) > $signed(best_q);
        best_d     = scan_gt ? scan_score : best_q;
        best_idx_d = scan_gt ? idx_q : best_idx_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ENG_RST;
            rst_cnt_q     <= '0;
            cnt_q         <= '0;
            run_cnt_q     <= '0;
            eng_input_q   <= '0;
            snap_q        <= '0;
            idx_q         <= '0;
            best_idx_q    <= '0;
            best_q        <= '0;
            label_q       <= '0;
            label_score_q <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                ENG_RST: begin
                    if (rst_cnt_q == rst_last) begin
                        rst_cnt_q <= '0;
                        state_q   <= LOAD;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (pix_valid) begin
                        eng_input_q[int'(cnt_q)*bitlength +: bitlength] <= pix_data;
                        if (cnt_at_last || pix_last) begin
                            cnt_q     <= '0;
                            run_cnt_q <= '0;
                            err_len_q <= (cnt_at_last != pix_last);
                            state_q   <= RUN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (eng_finish) begin
                        snap_q     <= eng_output;
                        best_q     <= eng_output[bitlength-1:0];
                        best_idx_q <= '0;
                        idx_q      <= label_width'(1);
                        state_q    <= SCAN;
                    end else if (timeout_cycles != 0 && run_cnt_q == run_last) begin
                        err_timeout_q <= 1'b1;
                        eng_input_q   <= '0;
                        state_q       <= ENG_RST;
                    end else begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
                end
                SCAN: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    idx_q      <= idx_q + 1'b1;
                    if (idx_q == cls_last_idx) begin
                        label_q       <= best_idx_d;
                        label_score_q <= best_d;
                        state_q       <= OUT;
                    end
                end
                OUT: begin
                    if (label_ready) begin
                        eng_input_q <= '0;
                        state_q     <= ENG_RST;
                    end
                end
                default: state_q <= ENG_RST;
            endcase
        end
    end

    assign eng_reset      = (state_q == ENG_RST);
    assign pix_ready      = (state_q == LOAD);
    assign eng_data_valid = (state_q == RUN);
    assign label_valid    = (state_q == OUT);
    assign eng_input      = eng_input_q;
    assign label          = label_q;
    assign label_score    = label_score_q;
    assign err_len        = err_len_q;
    assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_rbm_host_driver.sv
// Directed bench for rbm_host_driver: framing, argmax/ties, backpressure, timeout, async reset.
module tb_rbm_host_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_data;
    logic        pix_last;
    logic        eng_reset;
    logic        eng_data_valid;
    logic [47:0] eng_input;
    logic [35:0] eng_output;
    logic        eng_finish;
    logic        label_valid;
    logic        label_ready;
    logic [1:0]  label;
    logic [11:0] label_score;
    logic        err_len;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    rbm_host_driver #(
        .bitlength       (12),
        .input_dim       (4),
        .output_dim      (3),
        .cnt_width       (3),
        .label_width     (2),
        .eng_reset_cycles(2),
        .timeout_cycles  (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_last      (pix_last),
        .eng_reset     (eng_reset),
        .eng_data_valid(eng_data_valid),
        .eng_input     (eng_input),
        .eng_output    (eng_output),
        .eng_finish    (eng_finish),
        .label_valid   (label_valid),
        .label_ready   (label_ready),
        .label         (label),
        .label_score   (label_score),
        .err_len       (err_len),
        .err_timeout   (err_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [11:0] d, input logic l);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic load4(input logic [11:0] p0, input logic [11:0] p1,
                         input logic [11:0] p2, input logic [11:0] p3);
        send(p0, 1'b0);
        send(p1, 1'b0);
        send(p2, 1'b0);
        send(p3, 1'b1);
        check("load_dv", eng_data_valid, 1);
        check("load_input", eng_input, {p3, p2, p1, p0});
    endtask

    // Finish on the first RUN cycle, hold ready low for ready_delay cycles, then
    // walk back through the 2-cycle engine reset into LOAD.
    task automatic classify(input string tag, input logic [35:0] scores,
                            input logic [1:0] exp_lbl, input logic [11:0] exp_sc,
                            input int ready_delay);
        eng_output = scores;
        eng_finish = 1'b1;
        step();
        check({tag, "_dv_drop"}, eng_data_valid, 0);
        check({tag, "_lv_scan1"}, label_valid, 0);
        step();
        check({tag, "_lv_scan2"}, label_valid, 0);
        step();
        check({tag, "_lv"}, label_valid, 1);
        check({tag, "_label"}, label, exp_lbl);
        check({tag, "_score"}, label_score, exp_sc);
        for (int i = 0; i < ready_delay; i++) begin
            step();
            check({tag, "_hold_lv"}, label_valid, 1);
            check({tag, "_hold_label"}, label, exp_lbl);
            check({tag, "_hold_score"}, label_score, exp_sc);
        end
        label_ready = 1'b1;
        step();
        label_ready = 1'b0;
        check({tag, "_rst1"}, eng_reset, 1);
        check({tag, "_lv_off"}, label_valid, 0);
        check({tag, "_input_clr"}, eng_input, 0);
        check({tag, "_label_kept"}, label, exp_lbl);
        step();
        eng_finish = 1'b0;
        check({tag, "_rst2"}, eng_reset, 1);
        check({tag, "_rdy_off"}, pix_ready, 0);
        step();
        check({tag, "_rst_done"}, eng_reset, 0);
        check({tag, "_rdy_on"}, pix_ready, 1);
    endtask

    initial begin
        reset       = 1'b1;
        pix_valid   = 1'b0;
        pix_data    = '0;
        pix_last    = 1'b0;
        eng_output  = '0;
        eng_finish  = 1'b0;
        label_ready = 1'b0;
        step();
        step();
        check("rst_eng_reset", eng_reset, 1);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_dv", eng_data_valid, 0);
        check("rst_lv", label_valid, 0);
        check("rst_input", eng_input, 0);
        check("rst_label", {label, label_score}, 0);
        check("rst_err", {err_len, err_timeout}, 0);

        reset = 1'b0;
        step();
        check("rel_eng_reset1", eng_reset, 1);
        check("rel_pix_ready1", pix_ready, 0);
        step();
        check("rel_eng_reset_off", eng_reset, 0);
        check("rel_pix_ready_on", pix_ready, 1);
        check("rel_lv", label_valid, 0);

        // Frame 1: class 2 wins outright
        load4(12'h001, 12'h002, 12'h003, 12'h004);
        check("f1_pix_ready", pix_ready, 0);
        check("f1_err_len", err_len, 0);
        classify("f1", {12'h020, 12'hFF0, 12'h010}, 2'd2, 12'h020, 0);

        // Frame 2: classes 1 and 2 tie, lowest index wins; ready held off 5 cycles
        load4(12'h011, 12'h022, 12'h033, 12'h044);
        classify("f2", {12'h050, 12'h050, 12'h010}, 2'd1, 12'h050, 5);

        // Frame 3: all equal negative scores -> class 0
        load4(12'h100, 12'h200, 12'h300, 12'h400);
        classify("f3", {12'hF00, 12'hF00, 12'hF00}, 2'd0, 12'hF00, 0);

        // Frame 4: signed compare, -1 beats -2 and -2048
        load4(12'h7FF, 12'h800, 12'h001, 12'hFFF);
        classify("f4", {12'hFFF, 12'h800, 12'hFFE}, 2'd2, 12'hFFF, 0);

        // Short frame: last on 2nd pixel
        send(12'h00A, 1'b0);
        check("short_no_err_mid", err_len, 0);
        send(12'h00B, 1'b1);
        check("short_err_len", err_len, 1);
        check("short_input", eng_input, 48'h00000000B00A);
        check("short_dv", eng_data_valid, 1);
        step();
        check("short_err_pulse_end", err_len, 0);
        classify("short", {12'h001, 12'h003, 12'h002}, 2'd1, 12'h003, 0);

        // Long frame: 4th pixel without last
        send(12'h005, 1'b0);
        send(12'h006, 1'b0);
        send(12'h007, 1'b0);
        send(12'h008, 1'b0);
        check("long_err_len", err_len, 1);
        check("long_input", eng_input, 48'h008007006005);
        check("long_dv", eng_data_valid, 1);

        // Timeout: no finish for 8 RUN cycles
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_still_run", eng_data_valid, 1);
            check("to_no_pulse", err_timeout, 0);
        end
        step();
        check("to_pulse", err_timeout, 1);
        check("to_eng_reset", eng_reset, 1);
        check("to_dv_off", eng_data_valid, 0);
        check("to_lv", label_valid, 0);
        check("to_input_clr", eng_input, 0);
        step();
        check("to_pulse_end", err_timeout, 0);
        check("to_eng_reset2", eng_reset, 1);
        step();
        check("to_load", pix_ready, 1);

        // Async reset in the middle of RUN
        load4(12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD);
        step();
        #2;
        reset = 1'b1;
        #1;
        check("ar_dv", eng_data_valid, 0);
        check("ar_eng_reset", eng_reset, 1);
        check("ar_input", eng_input, 0);
        check("ar_err", {err_len, err_timeout}, 0);
        step();
        reset      = 1'b0;
        eng_finish = 1'b1;
        eng_output = {12'h010, 12'h020, 12'h030};
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_no_label", label_valid, 0);
            check("ar_no_err", {err_len, err_timeout}, 0);
        end
        check("ar_load", pix_ready, 1);
        check("ar_label_clr", {label, label_score}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
